// File: rtl/cache_ctrl_if.sv
// CPU, cache and backing-memory signal bundle for the cache controller.
// The slave modport is the controller; master is the surrounding CPU/cache/memory side.
interface cache_ctrl_if;
   logic        cpu_req;
   logic        cpu_we;
   logic [7:0]  cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_busy;
   logic        cpu_done;
   logic        cpu_err;
   logic [7:0]  cpu_rdata;
   logic [7:0]  cache_addr;
   logic [7:0]  cache_data;
   logic        cache_w_r;
   logic        cache_hit;
   logic [7:0]  cache_out;
   logic [7:0]  mem_addr;
   logic        mem_rd;
   logic        mem_wr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        mem_ready;
   logic [15:0] hit_cnt;
   logic [15:0] miss_cnt;

   modport slave (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
      input  cache_hit, cache_out, mem_rdata, mem_ready,
      output cpu_busy, cpu_done, cpu_err, cpu_rdata,
      output cache_addr, cache_data, cache_w_r,
      output mem_addr, mem_rd, mem_wr, mem_wdata,
      output hit_cnt, miss_cnt
   );

   modport master (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata,
      output cache_hit, cache_out, mem_rdata, mem_ready,
      input  cpu_busy, cpu_done, cpu_err, cpu_rdata,
      input  cache_addr, cache_data, cache_w_r,
      input  mem_addr, mem_rd, mem_wr, mem_wdata,
      input  hit_cnt, miss_cnt
   );
endinterface

// File: rtl/cache_ctrl.sv
// Write-through, write-allocate cache controller with memory-wait timeout
// and saturating read hit/miss counters. Moore FSM, all outputs registered.
module cache_ctrl #(
   parameter int TIMEOUT = 15
) (
   input logic         clk,
   input logic         reset,
   cache_ctrl_if.slave bus
);
   localparam int WaitW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [WaitW-1:0] WaitLimit = WaitW'(TIMEOUT);

   typedef enum logic [2:0] {
      IDLE, LOOKUP, MEM_RD, FILL, CWR, MEM_WR, DONE
   } state_e;

   state_e           state_q;
   logic             we_q, busy_q, done_q, err_q;
   logic             cacheWr_q, memRd_q, memWr_q;
   logic [7:0]       addr_q, wdata_q, rdata_q, cacheData_q;
   logic [15:0]      hitCnt_q, missCnt_q;
   logic [15:0]      hitCnt_d, missCnt_d;
   logic [WaitW-1:0] waitCnt_q;

   assign hitCnt_d  = (hitCnt_q  == 16'hFFFF) ? hitCnt_q  : hitCnt_q  + 16'd1;
   assign missCnt_d = (missCnt_q == 16'hFFFF) ? missCnt_q : missCnt_q + 16'd1;

   // cacheData_q doubles as the fill register on a read miss.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cacheWr_q   <= 1'b0;
         memRd_q     <= 1'b0;
         memWr_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rdata_q     <= '0;
         cacheData_q <= '0;
         hitCnt_q    <= '0;
         missCnt_q   <= '0;
         waitCnt_q   <= '0;
      end else begin
         done_q    <= 1'b0;
         cacheWr_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.cpu_req) begin
                  we_q    <= bus.cpu_we;
                  addr_q  <= bus.cpu_addr;
                  wdata_q <= bus.cpu_wdata;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (we_q) begin
                  cacheData_q <= wdata_q;
                  cacheWr_q   <= 1'b1;
                  state_q     <= CWR;
               end else if (bus.cache_hit) begin
                  rdata_q  <= bus.cache_out;
                  hitCnt_q <= hitCnt_d;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  missCnt_q <= missCnt_d;
                  memRd_q   <= 1'b1;
                  waitCnt_q <= '0;
                  state_q   <= MEM_RD;
               end
            end
            // A ready in the cycle the limit is reached still completes normally.
            MEM_RD: begin
               if (bus.mem_ready) begin
                  rdata_q     <= bus.mem_rdata;
                  cacheData_q <= bus.mem_rdata;
                  cacheWr_q   <= 1'b1;
                  memRd_q     <= 1'b0;
                  state_q     <= FILL;
               end else if (waitCnt_q == WaitLimit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  memRd_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            FILL: begin
               done_q  <= 1'b1;
               state_q <= DONE;
            end
            CWR: begin
               memWr_q   <= 1'b1;
               waitCnt_q <= '0;
               state_q   <= MEM_WR;
            end
            MEM_WR: begin
               if (bus.mem_ready) begin
                  memWr_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else if (waitCnt_q == WaitLimit) begin
                  err_q   <= 1'b1;
                  memWr_q <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  waitCnt_q <= waitCnt_q + 1'b1;
               end
            end
            DONE: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               memRd_q <= 1'b0;
               memWr_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.cpu_busy   = busy_q;
   assign bus.cpu_done   = done_q;
   assign bus.cpu_err    = err_q;
   assign bus.cpu_rdata  = rdata_q;
   assign bus.cache_addr = addr_q;
   assign bus.cache_data = cacheData_q;
   assign bus.cache_w_r  = cacheWr_q;
   assign bus.mem_addr   = addr_q;
   assign bus.mem_rd     = memRd_q;
   assign bus.mem_wr     = memWr_q;
   assign bus.mem_wdata  = wdata_q;
   assign bus.hit_cnt    = hitCnt_q;
   assign bus.miss_cnt   = missCnt_q;
endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: hit, miss, write-through, timeout boundary,
// mid-access reset, request holding and hit counter saturation.
module tb_cache_ctrl;
   localparam int TIMEOUT = 15;

   logic clk = 1'b0;
   logic reset;
   int   vecCount  = 0;
   int   missCount = 0;

   int         doneCyc, memRdCyc, memWrCyc, cacheWrCnt;
   logic [7:0] cacheWrData, cacheWrAddr, memAddrSeen, memWdataSeen, lookupAddr, lastRdata;
   logic       lastErr, overlapSeen, doneSeen;

   cache_ctrl_if bus ();

   cache_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      vecCount++;
      assert (observed === expected) else begin
         missCount++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Issues one request and plays cache/memory until cpu_done, recording what the controller did.
   // memDelay is the number of strobe cycles memory stays not-ready; -1 means never ready.
   task automatic applyStimulus(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                                input logic hit, input logic [7:0] cOut, input int memDelay,
                                input logic [7:0] mRdata, input logic holdReq);
      int k = 0;
      bus.cpu_req   = 1'b1;
      bus.cpu_we    = we;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.cache_hit = hit;
      bus.cache_out = cOut;
      bus.mem_rdata = mRdata;
      bus.mem_ready = 1'b0;
      doneCyc = -1; memRdCyc = 0; memWrCyc = 0; cacheWrCnt = 0;
      cacheWrData = '0; cacheWrAddr = '0; memAddrSeen = '0; memWdataSeen = '0;
      lastErr = 1'b0; lastRdata = '0;
      tick();
      if (!holdReq) bus.cpu_req = 1'b0;
      lookupAddr = bus.cache_addr;
      for (int cyc = 1; cyc <= 60 && doneCyc < 0; cyc++) begin
         if (bus.mem_rd) memRdCyc++;
         if (bus.mem_wr) begin
            memWrCyc++;
            memWdataSeen = bus.mem_wdata;
         end
         if (bus.mem_rd || bus.mem_wr) begin
            memAddrSeen   = bus.mem_addr;
            bus.mem_ready = (memDelay >= 0) && (k == memDelay);
            k++;
         end else begin
            bus.mem_ready = 1'b0;
         end
         if (bus.cache_w_r) begin
            cacheWrCnt++;
            cacheWrData = bus.cache_data;
            cacheWrAddr = bus.cache_addr;
         end
         if (int'(bus.mem_rd) + int'(bus.mem_wr) + int'(bus.cache_w_r) > 1) overlapSeen = 1'b1;
         if (bus.cpu_done) begin
            doneCyc   = cyc;
            lastErr   = bus.cpu_err;
            lastRdata = bus.cpu_rdata;
         end
         tick();
      end
      bus.mem_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      overlapSeen = 1'b0;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.cache_hit = 1'b0; bus.cache_out = '0; bus.mem_rdata = '0; bus.mem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstBusy",   16'(bus.cpu_busy),  16'h0);
      checkOutput("rstDone",   16'(bus.cpu_done),  16'h0);
      checkOutput("rstStrobe", 16'({bus.mem_rd, bus.mem_wr, bus.cache_w_r}), 16'h0);
      checkOutput("rstHitCnt", bus.hit_cnt,        16'h0);
      checkOutput("rstMissCnt", bus.miss_cnt,      16'h0);
      checkOutput("rstRdata",  16'(bus.cpu_rdata), 16'h0);
      reset = 1'b0;

      // Write addr 3 data 6, memory ready after 2 cycles.
      applyStimulus(1'b1, 8'd3, 8'd6, 1'b0, 8'd0, 2, 8'd0, 1'b0);
      checkOutput("wrDoneCyc",  16'(doneCyc),     16'd6);
      checkOutput("wrErr",      16'(lastErr),     16'h0);
      checkOutput("wrMemWrCyc", 16'(memWrCyc),    16'd3);
      checkOutput("wrMemRdCyc", 16'(memRdCyc),    16'd0);
      checkOutput("wrCacheCnt", 16'(cacheWrCnt),  16'd1);
      checkOutput("wrCacheDat", 16'(cacheWrData), 16'd6);
      checkOutput("wrCacheAdr", 16'(cacheWrAddr), 16'd3);
      checkOutput("wrMemAddr",  16'(memAddrSeen), 16'd3);
      checkOutput("wrMemWdata", 16'(memWdataSeen), 16'd6);
      checkOutput("wrHitCnt",   bus.hit_cnt,      16'd0);
      checkOutput("wrMissCnt",  bus.miss_cnt,     16'd0);
      checkOutput("wrIdleBusy", 16'(bus.cpu_busy), 16'h0);

      // Read addr 3, cache hit with 6.
      applyStimulus(1'b0, 8'd3, 8'd0, 1'b1, 8'd6, 0, 8'd0, 1'b0);
      checkOutput("hitDoneCyc", 16'(doneCyc),    16'd2);
      checkOutput("hitRdata",   16'(lastRdata),  16'd6);
      checkOutput("hitLookAdr", 16'(lookupAddr), 16'd3);
      checkOutput("hitHitCnt",  bus.hit_cnt,     16'd1);
      checkOutput("hitMemRd",   16'(memRdCyc),   16'd0);
      checkOutput("hitCacheWr", 16'(cacheWrCnt), 16'd0);

      // Read addr 18, miss, memory returns 59 after 3 cycles.
      applyStimulus(1'b0, 8'd18, 8'd0, 1'b0, 8'd0, 3, 8'd59, 1'b0);
      checkOutput("missDoneCyc", 16'(doneCyc),     16'd7);
      checkOutput("missRdata",   16'(lastRdata),   16'd59);
      checkOutput("missErr",     16'(lastErr),     16'h0);
      checkOutput("missMemRd",   16'(memRdCyc),    16'd4);
      checkOutput("missMemAddr", 16'(memAddrSeen), 16'd18);
      checkOutput("missFillCnt", 16'(cacheWrCnt),  16'd1);
      checkOutput("missFillDat", 16'(cacheWrData), 16'd59);
      checkOutput("missFillAdr", 16'(cacheWrAddr), 16'd18);
      checkOutput("missMissCnt", bus.miss_cnt,     16'd1);
      checkOutput("missHitCnt",  bus.hit_cnt,      16'd1);

      // Read miss with memory never ready: abort after TIMEOUT waiting cycles.
      applyStimulus(1'b0, 8'h40, 8'd0, 1'b0, 8'd0, -1, 8'hAA, 1'b0);
      checkOutput("toDoneCyc", 16'(doneCyc),    16'(TIMEOUT + 3));
      checkOutput("toErr",     16'(lastErr),    16'h1);
      checkOutput("toRdata",   16'(lastRdata),  16'h0);
      checkOutput("toMemRd",   16'(memRdCyc),   16'(TIMEOUT + 1));
      checkOutput("toNoFill",  16'(cacheWrCnt), 16'd0);
      checkOutput("toMissCnt", bus.miss_cnt,    16'd2);

      // Write where ready arrives exactly when the wait counter hits TIMEOUT; also clears err.
      applyStimulus(1'b1, 8'd7, 8'h5A, 1'b0, 8'd0, TIMEOUT, 8'd0, 1'b0);
      checkOutput("edgeDoneCyc", 16'(doneCyc),  16'(TIMEOUT + 4));
      checkOutput("edgeErr",     16'(lastErr),  16'h0);
      checkOutput("edgeMemWr",   16'(memWrCyc), 16'(TIMEOUT + 1));
      checkOutput("edgeErrIdle", 16'(bus.cpu_err), 16'h0);

      // Reset during the second MEM_RD cycle.
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 8'h21;
      bus.cache_hit = 1'b0; bus.mem_ready = 1'b0;
      tick();
      bus.cpu_req = 1'b0;
      tick();
      tick();
      checkOutput("rstPreMemRd", 16'(bus.mem_rd), 16'h1);
      #2 reset = 1'b1;
      #1;
      checkOutput("rstMidMemRd", 16'(bus.mem_rd),   16'h0);
      checkOutput("rstMidBusy",  16'(bus.cpu_busy), 16'h0);
      checkOutput("rstMidMiss",  bus.miss_cnt,      16'h0);
      doneSeen = 1'b0;
      repeat (2) begin
         tick();
         if (bus.cpu_done) doneSeen = 1'b1;
      end
      reset = 1'b0;
      repeat (2) begin
         tick();
         if (bus.cpu_done) doneSeen = 1'b1;
      end
      checkOutput("rstNoDone", 16'(doneSeen), 16'h0);

      // First read after reset is accepted normally.
      applyStimulus(1'b0, 8'h21, 8'd0, 1'b1, 8'h33, 0, 8'd0, 1'b0);
      checkOutput("postRstDone",  16'(doneCyc),   16'd2);
      checkOutput("postRstRdata", 16'(lastRdata), 16'h33);
      checkOutput("postRstHit",   bus.hit_cnt,    16'd1);

      // Preload the hit counter, then a miss with cpu_req held high throughout.
      force dut.hitCnt_q = 16'hFFFF;
      #1;
      release dut.hitCnt_q;
      applyStimulus(1'b0, 8'h50, 8'd0, 1'b0, 8'd0, 0, 8'h77, 1'b1);
      checkOutput("holdDoneCyc", 16'(doneCyc),      16'd4);
      checkOutput("holdRdata",   16'(lastRdata),    16'h77);
      checkOutput("holdMiss",    bus.miss_cnt,      16'd1);
      checkOutput("holdIdle",    16'(bus.cpu_busy), 16'h0);

      // The still-high request now starts exactly one new access: a hit that must saturate.
      applyStimulus(1'b0, 8'h50, 8'd0, 1'b1, 8'h77, 0, 8'd0, 1'b0);
      checkOutput("satDoneCyc", 16'(doneCyc),   16'd2);
      checkOutput("satHitCnt",  bus.hit_cnt,    16'hFFFF);
      checkOutput("satMiss",    bus.miss_cnt,   16'd1);

      checkOutput("noOverlap", 16'(overlapSeen), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule

// File: doc/cache_ctrl.md
CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent waiting for mem_ready before the controller aborts the access.
REQ-002 clk  input  1  system clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_req  input  1  request strobe, sampled only in IDLE.
REQ-005 cpu_we  input  1  1 = write, 0 = read; latched with cpu_req.
REQ-006 cpu_addr  input  8  request address; latched with cpu_req.
REQ-007 cpu_wdata  input  8  write data; latched with cpu_req.
REQ-008 cpu_busy  output  1  high in every state except IDLE.
REQ-009 cpu_done  output  1  one-cycle completion pulse.
REQ-010 cpu_err  output  1  valid with cpu_done; 1 = memory timeout.
REQ-011 cpu_rdata  output  8  read result; held until the next completion.
REQ-012 cache_addr  output  8  cache address port; equals the latched address.
REQ-013 cache_data  output  8  cache write data.
REQ-014 cache_w_r  output  1  cache write enable (1 = write).
REQ-015 cache_hit  input  1  cache hit flag, valid one cycle after cache_addr changes.
REQ-016 cache_out  input  8  cache read data, valid alongside cache_hit.
REQ-017 mem_addr  output  8  backing-memory address; equals the latched address.
REQ-018 mem_rd  output  1  memory read strobe.
REQ-019 mem_wr  output  1  memory write strobe.
REQ-020 mem_wdata  output  8  memory write data; equals the latched write data.
REQ-021 mem_rdata  input  8  memory read data, valid when mem_ready is high.
REQ-022 mem_ready  input  1  memory completion; acts on the current access.
REQ-023 hit_cnt  output  16  read-hit count.
REQ-024 miss_cnt  output  16  read-miss count.

Function
REQ-025 The controller SHALL be a Moore FSM with states IDLE, LOOKUP, MEM_RD, FILL, CWR, MEM_WR and DONE.
REQ-026 In IDLE, cpu_req=1 SHALL latch cpu_we, cpu_addr and cpu_wdata, then go to LOOKUP.
REQ-027 Any cpu_req received outside IDLE SHALL be ignored; the controller does not queue requests.
REQ-028 LOOKUP SHALL last one cycle with cache_w_r=0; cache_hit and cache_out are sampled at the end of that cycle.
REQ-029 LOOKUP exit, read with hit: capture cpu_rdata=cache_out, increment hit_cnt, go to DONE.
REQ-030 LOOKUP exit, read with miss: increment miss_cnt, go to MEM_RD.
REQ-031 LOOKUP exit, any write: go to CWR; the hit state is ignored and no counter changes.
REQ-032 MEM_RD SHALL hold mem_rd=1 until mem_ready=1.
REQ-033 MEM_RD exit: capture mem_rdata into cpu_rdata and the fill register, then go to FILL.
REQ-034 FILL SHALL assert cache_w_r=1 with cache_data equal to the fill register for exactly one cycle, then go to DONE.
REQ-035 CWR SHALL assert cache_w_r=1 with cache_data equal to the latched wdata for exactly one cycle, then go to MEM_WR; writes are write-through with write-allocate.
REQ-036 MEM_WR SHALL hold mem_wr=1 until mem_ready=1, then go to DONE.
REQ-037 The wait counter SHALL clear on entry to MEM_RD or MEM_WR and increment each cycle mem_ready=0.
REQ-038 If the wait counter reaches TIMEOUT, the controller SHALL set err and go to DONE; on a read it sets cpu_rdata=0 and skips FILL.
REQ-039 A mem_ready=1 arriving in the same cycle as the timeout SHALL take precedence; the access completes normally.
REQ-040 DONE SHALL assert cpu_done=1 for one cycle, with cpu_err set from the err flag, then go to IDLE.
REQ-041 The err flag SHALL clear when the next request is accepted.
REQ-042 Latency, read hit: cpu_done is high in the 2nd cycle after the accepting edge.
REQ-043 Latency, read miss: cpu_done is high 4+N cycles after the accepting edge, where N is the number of cycles mem_ready stays low.
REQ-044 Latency, write: cpu_done is high 4+N cycles after the accepting edge, where N is the number of cycles mem_ready stays low.
REQ-045 hit_cnt and miss_cnt SHALL saturate at 16'hFFFF.
REQ-046 mem_rd, mem_wr and cache_w_r SHALL never be high simultaneously.
REQ-047 mem_ready while neither mem_rd nor mem_wr is high SHALL be ignored.

Reset
REQ-048 On reset assertion, the FSM SHALL go to IDLE immediately, without waiting for a clock edge.
REQ-049 On reset assertion, all outputs, counters, latches and the wait counter SHALL go to 0 immediately.
REQ-050 A reset during MEM_RD, MEM_WR, FILL or CWR SHALL drop all strobes asynchronously and produce no cpu_done.
REQ-051 The first request SHALL be accepted on the first rising edge after reset deassertion with cpu_req=1.

Verification
REQ-052 Write addr=3, wdata=6, memory ready after 2 cycles -> CWR writes 6 to cache addr 3; mem_wr high 3 cycles; cpu_done with err=0; counters unchanged.
REQ-053 Read addr=3 after REQ-052, cache_hit=1 and cache_out=6 -> cpu_rdata=6; done in 2nd cycle; hit_cnt=1; mem_rd never high.
REQ-054 Read addr=18, cache_hit=0, memory returns 59 after 3 cycles -> FILL writes 59 to cache addr 18; cpu_rdata=59; miss_cnt=1; done at cycle 7.
REQ-055 Read miss with mem_ready stuck low, TIMEOUT=15 -> cpu_done with err=1 and cpu_rdata=0; no FILL write; next request clears err.
REQ-056 Reset asserted during the 2nd MEM_RD cycle -> mem_rd drops before the next edge; no cpu_done; cpu_busy=0; the next read is accepted normally.
REQ-057 cpu_req held high through an entire miss -> exactly one access; a second access starts only after DONE returns to IDLE; preload hit_cnt to FFFF and confirm saturation.
